// File: rtl/spi_pkg.sv
// Shared constants for the SPI block: word/pointer widths, register map and
// STATUS bit positions, plus a helper that assembles the FIFO status bits.
package spi_pkg;

  localparam int SPI_WORD_W  = 32;
  localparam int FIFO_ADDR_W = 4;

  localparam logic [1:0] DATA_REG   = 2'd0;
  localparam logic [1:0] STATUS_REG = 2'd1;
  localparam logic [1:0] CTRL_REG   = 2'd2;
  localparam logic [1:0] BRD_REG    = 2'd3;

  localparam int TXFE = 5;
  localparam int TXFF = 4;
  localparam int TXFO = 3;
  localparam int RXFE = 2;
  localparam int RXFF = 1;
  localparam int RXFO = 0;

  typedef struct packed {
    logic empty;
    logic full;
    logic ov;
  } fifo_status_t;

  // Places the TX and RX queue flags at their STATUS register positions.
  function automatic logic [5:0] pack_status(input fifo_status_t tx,
                                             input fifo_status_t rx);
    logic [5:0] s;
    s       = '0;
    s[TXFE] = tx.empty;
    s[TXFF] = tx.full;
    s[TXFO] = tx.ov;
    s[RXFE] = rx.empty;
    s[RXFF] = rx.full;
    s[RXFO] = rx.ov;
    return s;
  endfunction

endpackage

// File: rtl/spi_fifo_mem.sv
// Simple dual-port word store: one synchronous write port, one asynchronous
// read port, no reset, so it can map onto distributed/MLAB memory.
module spi_fifo_mem #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/spi_word_fifo.sv
// First-word-fall-through word FIFO between the Avalon registers and the SPI
// serializer; flags are registered from next-state occupancy.
module spi_word_fifo
  import spi_pkg::*;
#(
  parameter int WIDTH    = SPI_WORD_W,
  parameter int ADDR_W   = FIFO_ADDR_W,
  parameter int AF_LEVEL = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              ov,
  output logic              uf,
  input  logic              clear_ov,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W-1:0] wr_ptr
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(2**ADDR_W);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);

  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              af_q, af_d;
  logic              ov_q, ov_d;
  logic              uf_q, uf_d;
  logic              do_push, do_pop;
  logic [WIDTH-1:0]  mem_rdata;

  always_comb begin
    do_pop   = rd_en & ~empty_q;
    // A pop in the same cycle frees the slot, so a push into a full queue proceeds.
    do_push  = wr_en & (~full_q | do_pop);

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);

    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);

    // Clear first so a same-cycle error event re-sets the sticky bit.
    ov_d = clear_ov ? 1'b0 : ov_q;
    uf_d = clear_ov ? 1'b0 : uf_q;
    if (wr_en && !do_push) ov_d = 1'b1;
    if (rd_en && empty_q)  uf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ov_q     <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ov_q     <= ov_d;
      uf_q     <= uf_d;
    end
  end

  spi_fifo_mem #(
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (do_push & ~reset),
    .waddr(wr_ptr_q),
    .wdata(wr_data),
    .raddr(rd_ptr_q),
    .rdata(mem_rdata)
  );

  assign rd_data     = empty_q ? '0 : mem_rdata;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = af_q;
  assign ov          = ov_q;
  assign uf          = uf_q;
  assign count       = count_q;
  assign rd_ptr      = rd_ptr_q;
  assign wr_ptr      = wr_ptr_q;

endmodule

// File: tb/tb_spi_word_fifo.sv
// Directed plus randomized bench for spi_word_fifo against a queue-based
// reference model of the FIFO rules.
module tb_spi_word_fifo;

  localparam int W  = 32;
  localparam int AW = 4;
  localparam int D  = 16;
  localparam int AF = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          clear_ov = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic [W-1:0]  rd_data;
  logic          full, empty, almost_full, ov, uf;
  logic [AW:0]   count;
  logic [AW-1:0] rd_ptr, wr_ptr;

  always #5 clk = ~clk;

  spi_word_fifo #(.WIDTH(W), .ADDR_W(AW), .AF_LEVEL(AF)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .full(full), .empty(empty),
    .almost_full(almost_full), .ov(ov), .uf(uf), .clear_ov(clear_ov),
    .count(count), .rd_ptr(rd_ptr), .wr_ptr(wr_ptr)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: contents as a queue, pointers as modular counters.
  logic [W-1:0] mq[$];
  int m_rp = 0, m_wp = 0;
  bit m_ov = 0, m_uf = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit we, input logic [W-1:0] wd, input bit re,
                       input bit clr, input bit rst);
    int n;
    bit was_full, was_empty, pop_ok, push_ok;
    if (rst) begin
      mq.delete();
      m_rp = 0; m_wp = 0; m_ov = 0; m_uf = 0;
      return;
    end
    n = mq.size();
    was_full  = (n == D);
    was_empty = (n == 0);
    pop_ok  = re && !was_empty;
    push_ok = we && (n - (pop_ok ? 1 : 0) < D);
    if (pop_ok)  begin void'(mq.pop_front()); m_rp = (m_rp + 1) % D; end
    if (push_ok) begin mq.push_back(wd);      m_wp = (m_wp + 1) % D; end
    if (clr) begin m_ov = 0; m_uf = 0; end
    if (we && !push_ok) m_ov = 1;
    if (re && was_empty) m_uf = 1;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, ":count"}, count, n);
    chk({tag, ":empty"}, empty, (n == 0));
    chk({tag, ":full"},  full,  (n == D));
    chk({tag, ":af"},    almost_full, (n >= AF));
    chk({tag, ":ov"},    ov, m_ov);
    chk({tag, ":uf"},    uf, m_uf);
    chk({tag, ":rd_data"}, rd_data, (n != 0) ? mq[0] : W'(0));
    chk({tag, ":rd_ptr"},  rd_ptr, m_rp);
    chk({tag, ":wr_ptr"},  wr_ptr, m_wp);
  endtask

  task automatic step(input string tag, input bit we, input logic [W-1:0] wd,
                      input bit re, input bit clr, input bit rst);
    wr_en = we; wr_data = wd; rd_en = re; clear_ov = clr; reset = rst;
    @(posedge clk);
    model(we, wd, re, clr, rst);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [W-1:0] last;

    // 1: reset then idle
    step("rst", 0, '0, 0, 0, 1);
    step("rst2", 1, 32'hFFFF, 1, 0, 1);
    step("idle", 0, '0, 0, 0, 0);
    chk("idle:empty_c", empty, 1);
    chk("idle:count_c", count, 0);
    chk("idle:rd_data_c", rd_data, 0);

    // 2: three pushes, three pops
    step("p2", 1, 32'hCE, 0, 0, 0);
    chk("p2:first_word", rd_data, 32'hCE);
    step("p2", 1, 32'h11, 0, 0, 0);
    step("p2", 1, 32'h22, 0, 0, 0);
    step("p2pop", 0, '0, 1, 0, 0);
    chk("p2:second", rd_data, 32'h11);
    step("p2pop", 0, '0, 1, 0, 0);
    chk("p2:third", rd_data, 32'h22);
    step("p2pop", 0, '0, 1, 0, 0);
    chk("p2:rd_ptr3", rd_ptr, 3);
    chk("p2:wr_ptr3", wr_ptr, 3);

    // 3: fill, overflow, drain, clear
    for (int i = 0; i < D; i++) step("fill", 1, W'(i), 0, 0, 0);
    chk("fill:full_c", full, 1);
    step("ovf", 1, 32'hDEAD, 0, 0, 0);
    chk("ovf:ov_c", ov, 1);
    for (int i = 0; i < D; i++) begin
      chk("drain:order", rd_data, W'(i));
      step("drain", 0, '0, 1, 0, 0);
    end
    step("clr", 0, '0, 0, 1, 0);
    chk("clr:ov_c", ov, 0);

    // 4: push+pop while full
    for (int i = 0; i < D; i++) step("fill4", 1, W'(i), 0, 0, 0);
    step("both_full", 1, 32'h99, 1, 0, 0);
    chk("both_full:head", rd_data, 1);
    chk("both_full:ov_c", ov, 0);
    last = '0;
    while (!empty && checks < 20000) begin
      last = rd_data;
      step("drain4", 0, '0, 1, 0, 0);
    end
    chk("drain4:last", last, 32'h99);

    // 5: pop on empty with push, then clear vs. new underflow
    step("uf", 1, 32'h55, 1, 0, 0);
    chk("uf:uf_c", uf, 1);
    chk("uf:data_c", rd_data, 32'h55);
    step("uf_pop", 0, '0, 1, 0, 0);
    step("uf_clr", 0, '0, 1, 1, 0);
    chk("uf_clr:set_wins", uf, 1);
    step("clr5", 0, '0, 0, 1, 0);

    // 6: push/pop pairs across wrap, then reset at count 7
    for (int i = 0; i < 40; i++) begin
      step("wrap_push", 1, $urandom, 0, 0, 0);
      step("wrap_pop", 0, '0, 1, 0, 0);
    end
    for (int i = 0; i < 7; i++) step("to7", 1, $urandom, 0, 0, 0);
    chk("to7:count_c", count, 7);
    step("mid_rst", 1, 32'h1234, 1, 0, 1);
    chk("mid_rst:count_c", count, 0);
    chk("mid_rst:rd_ptr_c", rd_ptr, 0);
    chk("mid_rst:wr_ptr_c", wr_ptr, 0);

    // Randomized traffic with biased push/pop rates to hit both boundaries
    for (int i = 0; i < 400; i++) begin
      bit we, re, clr, rst;
      int bias;
      bias = (i / 100) % 2 ? 30 : 70;
      we  = ($urandom_range(99) < bias);
      re  = ($urandom_range(99) < 100 - bias);
      clr = ($urandom_range(19) == 0);
      rst = ($urandom_range(199) == 0);
      step("rand", we, $urandom, re, clr, rst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_word_fifo.md
Name: spi_word_fifo

Overview:
Synchronous first-word-fall-through FIFO that buffers 32-bit words between the Avalon register interface and the SPI serializer.
- One instance sits upstream of the serializer as the TX queue: Avalon write to DATA pushes, serializer word-done pops.
- A second instance sits downstream as the RX queue: serializer word-done pushes, Avalon read of DATA pops.
- Provides the full, empty and sticky overflow status bits, plus occupancy and pointer debug outputs for the STATUS register and HEX displays.

Parameters:
WIDTH, 32, data word width in bits
ADDR_W, 4, pointer width; depth = 2**ADDR_W (16 words)
AF_LEVEL, 12, occupancy at or above which almost_full asserts

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
wr_en  in  1  push strobe; single-cycle pulse; caller does edge detection
wr_data  in  WIDTH  word to push
rd_en  in  1  pop strobe; single-cycle pulse
rd_data  out  WIDTH  head-of-queue word (show-ahead)
full  out  1  occupancy == depth
empty  out  1  occupancy == 0
almost_full  out  1  occupancy >= AF_LEVEL
ov  out  1  sticky overflow: push attempted while full
uf  out  1  sticky underflow: pop attempted while empty
clear_ov  in  1  W1C pulse; clears ov and uf
count  out  ADDR_W+1  current occupancy, 0..depth
rd_ptr  out  ADDR_W  read pointer (debug/HEX)
wr_ptr  out  ADDR_W  write pointer (debug/HEX)

Behaviour:
Clocking and reset:
- All state updates on posedge clk. Reset is synchronous, active-high, and has priority over everything else.
- Reset values: rd_ptr=0, wr_ptr=0, count=0, empty=1, full=0, almost_full=0, ov=0, uf=0.
- Storage array is not reset.
- Reset mid-traffic discards all contents; strobes in the reset cycle are ignored.

Output timing:
- rd_data = empty ? 0 : mem[rd_ptr]. This is combinational from registered state, with zero latency.
- The serializer samples rd_data before asserting rd_en.

Push:
- wr_en & !full: mem[wr_ptr] <= wr_data; wr_ptr <= wr_ptr+1, wrapping modulo depth.
- Pushed word is visible on rd_data the next cycle if the FIFO was empty.

Pop:
- rd_en & !empty: rd_ptr <= rd_ptr+1, wrapping modulo depth.

Count:
- count +1 on push only, -1 on pop only, unchanged on both or neither.
- full, empty and almost_full are registered, derived from next-state count, so they are valid in the same cycle as count.

Simultaneous events:
- wr_en & rd_en while full: pop and push both occur; data is not lost; full stays 1; ov is not set.
- wr_en & rd_en while empty: push occurs, pop is ignored, uf is set; next cycle count=1.
- wr_en & full (no rd_en): word dropped, pointers unchanged, ov <= 1.
- rd_en & empty: no pointer change, uf <= 1.

Sticky flags:
- clear_ov clears ov and uf.
- If clear_ov and a new overflow/underflow event occur in the same cycle, the set wins.

Wrap-around:
- Pointers are plain ADDR_W-bit counters; full/empty come from count, not from pointer compare.

Decomposition:
- Shared package spi_pkg holds: SPI_WORD_W=32; FIFO_ADDR_W=4; register address constants DATA_REG=0, STATUS_REG=1, CTRL_REG=2, BRD_REG=3.
- spi_pkg also holds STATUS bit positions: TXFE=5, TXFF=4, TXFO=3, RXFE=2, RXFF=1, RXFO=0.
- One natural sub-module: spi_fifo_mem, a simple dual-port array with one write port and an asynchronous read port, so it can later map to MLAB.
- All counters and flags stay in spi_word_fifo.

Test Plan:
1. Reset then idle -> empty=1, full=0, count=0, rd_data=0, ov=0, uf=0.
2. Push 0xCE, 0x11, 0x22, then pop three times -> rd_data shows 0xCE, 0x11, 0x22 in order; empty=1 after third pop; rd_ptr=wr_ptr=3.
3. Push 16 words 0..15 -> full=1 and almost_full=1 (from count 12); 17th push 0xDEAD -> ov=1, dropped; popping 16 words yields 0..15; clear_ov -> ov=0.
4. Fill to 16, then wr_en&rd_en with 0x99 -> count stays 16, ov=0, head advances to 1; after draining, the last word is 0x99.
5. Pop when empty together with push 0x55 -> uf=1, count=1, rd_data=0x55; then clear_ov asserted in the same cycle as another empty pop -> uf remains 1.
6. 40 push/pop pairs interleaved across pointer wrap, then reset asserted with count=7 -> data order preserved through wrap; after reset count=0, empty=1, pointers=0.
